// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind uart_rx: buffers strobed characters until the consumer reads them.
// Flags dropped characters with a sticky overflow bit.
module uart_rx_fifo #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          rcv,
   input  logic [7:0]    data,
   input  logic          rd,
   output logic [7:0]    dout,
   output logic          dvalid,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          ovf,
   input  logic          ovf_clr
);
   localparam int DEPTH = 2**AW;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    dout_q;
   logic          dvalid_q;
   logic          ovf_q, ovf_d;
   logic          rd_ok, wr_ok, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

   // A read on the same edge frees the slot, so a write into a full FIFO is still accepted.
   assign rd_ok = rd & ~empty;
   assign wr_ok = rcv & (~full | rd_ok);
   assign drop  = rcv & ~wr_ok;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         dvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         dvalid_q <= rd_ok;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is never reset; write-first is avoided so a full-FIFO read+write returns the old head.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr_q] <= data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      dout_q <= 8'h00;
      else if (rd_ok) dout_q <= mem[rptr_q];
   end

   assign dout   = dout_q;
   assign dvalid = dvalid_q;
   assign count  = count_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_uart_rx_fifo;
   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          rcv = 1'b0;
   logic [7:0]    data = 8'h00;
   logic          rd = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [7:0]    dout;
   logic          dvalid, empty, full, ovf;
   logic [AW:0]   count;

   uart_rx_fifo #(.AW(AW)) dut (
      .clk(clk), .rstn(rstn), .rcv(rcv), .data(data), .rd(rd),
      .dout(dout), .dvalid(dvalid), .empty(empty), .full(full),
      .count(count), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [7:0] mq[$];
   logic [7:0] m_dout;
   logic       m_dvalid;
   logic       m_ovf;
   bit         saw_ee;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout   = 8'h00;
      m_dvalid = 1'b0;
      m_ovf    = 1'b0;
   endtask

   task automatic model_step(input logic r, input logic [7:0] d, input logic rq, input logic clr);
      bit rok, wok;
      rok = rq && (mq.size() > 0);
      wok = r && (mq.size() < DEPTH || rok);
      m_dvalid = rok;
      if (rok) m_dout = mq.pop_front();
      if (wok) mq.push_back(d);
      if (r && !wok)  m_ovf = 1'b1;
      else if (clr)   m_ovf = 1'b0;
   endtask

   task automatic check_all();
      chk("count",  32'(count),  32'(mq.size()));
      chk("empty",  32'(empty),  32'(mq.size() == 0));
      chk("full",   32'(full),   32'(mq.size() == DEPTH));
      chk("dout",   32'(dout),   32'(m_dout));
      chk("dvalid", 32'(dvalid), 32'(m_dvalid));
      chk("ovf",    32'(ovf),    32'(m_ovf));
      if (dvalid && dout == 8'hEE) saw_ee = 1'b1;
   endtask

   task automatic step(input logic r, input logic [7:0] d, input logic rq, input logic clr);
      @(negedge clk);
      rcv = r; data = d; rd = rq; ovf_clr = clr;
      @(posedge clk);
      model_step(r, d, rq, clr);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      saw_ee = 1'b0;
      model_reset();

      // reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dout",  32'(dout),  32'h00);
      chk("rst_dvalid",32'(dvalid),32'd0);
      chk("rst_ovf",   32'(ovf),   32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // single character
      step(1'b1, 8'h41, 1'b0, 1'b0);
      chk("single_cnt1", 32'(count), 32'd1);
      idle();
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("single_dout", 32'(dout), 32'h41);
      chk("single_dv",   32'(dvalid), 32'd1);
      chk("single_cnt0", 32'(count), 32'd0);
      idle();
      chk("single_dv_off", 32'(dvalid), 32'd0);
      chk("single_hold",   32'(dout), 32'h41);

      // fill and wrap
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd16);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("wrap_rd1", 32'(dout), 32'(i));
      end
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("wrap_rd2", 32'(dout), 32'(8'h0A + i));
      end
      chk("wrap_empty", 32'(empty), 32'd1);

      // overflow and sticky flag
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_set",   32'(ovf),   32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("ovf_setwins", 32'(ovf), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", 32'(ovf), 32'd0);

      // full with simultaneous rcv+rd
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("fullrw_count", 32'(count), 32'd16);
      chk("fullrw_ovf",   32'(ovf),   32'd0);
      chk("fullrw_head",  32'(dout),  32'h20);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fullrw_last", 32'(dout), 32'h77);
      chk("no_ee", 32'(saw_ee), 32'd0);

      // empty with simultaneous rcv+rd
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("emptyrw_dv",  32'(dvalid), 32'd0);
      chk("emptyrw_cnt", 32'(count),  32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("emptyrw_dout", 32'(dout), 32'h55);

      // async reset mid-burst: ovf set, count 7, dvalid high, read pending
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_cnt", 32'(count), 32'd7);
      @(negedge clk);
      rcv = 1'b0; rd = 1'b1; ovf_clr = 1'b0;
      #1 rstn = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_dout",  32'(dout),  32'h00);
      chk("arst_dv",    32'(dvalid),32'd0);
      chk("arst_ovf",   32'(ovf),   32'd0);
      @(posedge clk);
      #1;
      chk("arst_nodv", 32'(dvalid), 32'd0);
      @(negedge clk);
      rd = 1'b0;
      rstn = 1'b1;
      model_reset();

      // randomized traffic in phases of varying pressure
      for (int ph = 0; ph < 8; ph++) begin
         int prcv, prd;
         prcv = $urandom_range(10, 95);
         prd  = $urandom_range(10, 95);
         for (int c = 0; c < 300; c++) begin
            step(1'($urandom_range(0, 99) < prcv), 8'($urandom),
                 1'($urandom_range(0, 99) < prd), 1'($urandom_range(0, 15) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
